// File: rtl/serial_pkg.sv
// Shared serial-line definitions: FSM state encoding and frame bit counts,
// common to the serial_out transmitter and the serial_in receiver.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } serial_state_t;

    localparam int DATA_BITS         = 8;
    localparam int FRAME_BITS_PLAIN  = 10;
    localparam int FRAME_BITS_PARITY = 11;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with show-ahead read data; writes when full and reads when empty
// are dropped. DEPTH must be a power of two so the pointers wrap naturally.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_ok, rd_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_out.sv
// Buffered UART-style transmitter with cts_n flow control.
// Define SERIAL_OUT_PARITY_EN to add an even-parity bit (11-bit frames).
module serial_out
    import serial_pkg::*;
#(
    parameter int CLK_FREQUENCY_HZ = 108_000_000,
    parameter int SERIAL_BPS       = 3_000_000,
    parameter int FIFO_DEPTH       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       ie,
    output logic       ready,
    input  logic       cts_n,
    output logic       tx,
    output logic       busy
);

    localparam int DIVIDER = CLK_FREQUENCY_HZ / SERIAL_BPS;
    localparam int CW      = $clog2(DIVIDER);

    serial_state_t                 state, next_state;
    logic [CW-1:0]                 cnt;
    logic [2:0]                    bit_idx;
    logic [7:0]                    shreg;
    logic [7:0]                    head;
    logic                          full, empty, pop, bit_done, tx_next, frame_tail;
    logic [$clog2(FIFO_DEPTH):0]   count;
`ifdef SERIAL_OUT_PARITY_EN
    logic                          par;
`endif

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ie),
        .wr_data (data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign ready    = !full;
    assign bit_done = (cnt == CW'(DIVIDER - 1));
    // frame_tail covers the last stop-bit cycle still on the registered tx line
    assign busy     = (state != IDLE) || (count != '0) || frame_tail;

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                if (!empty && !cts_n) begin
                    next_state = START;
                    pop        = 1'b1;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (bit_done) next_state = DATA;
            end
            DATA: begin
                tx_next = shreg[0];
                if (bit_done && bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef SERIAL_OUT_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef SERIAL_OUT_PARITY_EN
            PARITY: begin
                tx_next = par;
                if (bit_done) next_state = STOP;
            end
`endif
            STOP: begin
                tx_next = 1'b1;
                if (bit_done) begin
                    if (!empty && !cts_n) begin
                        next_state = START;
                        pop        = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            frame_tail <= 1'b0;
        end else begin
            state      <= next_state;
            tx         <= tx_next;
            frame_tail <= (state != IDLE);
            cnt        <= (state == IDLE || bit_done) ? '0 : cnt + CW'(1);
            if (state == DATA && bit_done) bit_idx <= bit_idx + 3'd1;
            if (pop)
                shreg <= head;
            else if (state == DATA && bit_done)
                shreg <= {1'b0, shreg[7:1]};
        end
    end

`ifdef SERIAL_OUT_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   par <= 1'b0;
        else if (pop) par <= even_parity(head);
    end
`endif

endmodule

// File: doc/serial_out.md
SERIAL_OUT -- requirements
Module: serial_out

Interface
REQ-001 SHALL have parameter CLK_FREQUENCY_HZ, default 108_000_000, system clock frequency.
REQ-002 SHALL have parameter SERIAL_BPS, default 3_000_000, line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two, transmit buffer entries.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 data  input  8  byte to transmit.
REQ-007 ie  input  1  data valid; byte accepted on any clk edge where ie=1 and ready=1.
REQ-008 ready  output  1  high when the FIFO is not full.
REQ-009 cts_n  input  1  remote clear-to-send, active low; already synchronised by the caller.
REQ-010 tx  output  1  serial line, idle high.
REQ-011 busy  output  1  high while a frame is on the line or the FIFO is non-empty.

Function
REQ-012 Bit period SHALL be DIVIDER = CLK_FREQUENCY_HZ / SERIAL_BPS cycles (integer division; 36 at defaults); the counter SHALL be $clog2(DIVIDER) bits wide.
REQ-013 Frame SHALL be 1 start bit (0), 8 data bits LSB first, optional parity (REQ-024), 1 stop bit (1).
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE->START when FIFO non-empty and cts_n=0; START->DATA, DATA->PARITY or STOP after bit 7, PARITY->STOP, STOP->IDLE, each after exactly DIVIDER cycles.
REQ-015 IDLE->START transition SHALL pop the FIFO head into a shift register on the same edge.
REQ-016 Latency: ie on edge N into an empty FIFO while IDLE with cts_n=0 SHALL drive tx=0 from edge N+2.
REQ-017 cts_n SHALL be sampled only in IDLE; deasserting it mid-frame SHALL NOT truncate the frame.
REQ-018 Back-to-back frames: STOP->START SHALL NOT insert idle cycles beyond DIVIDER-cycle stop bit if the FIFO is non-empty and cts_n=0 (STOP exits directly to START).
REQ-019 Write while full (ie=1, ready=0) SHALL be ignored; no FIFO state change.
REQ-020 Simultaneous write and pop on a full FIFO SHALL accept the write only if ready was high on that edge (ready reflects registered count; no bypass).
REQ-021 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.

Reset
REQ-022 On rst_n=0, asynchronously: state=IDLE, tx=1, busy=0, ready=1, FIFO empty, counters zero.
REQ-023 Reset asserted mid-frame SHALL abort the frame; tx SHALL return high immediately and buffered bytes SHALL be discarded.

Configuration
REQ-024 Macro SERIAL_OUT_PARITY_EN defined: PARITY state present, transmits even parity (XOR of 8 data bits), frame = 11 bit periods.
REQ-025 Macro undefined: PARITY state and parity logic absent, frame = 10 bit periods.

Structure
REQ-026 FSM state enum and the frame bit-count constants SHALL live in shared package serial_pkg, reused by serial_in.
REQ-027 The FIFO SHALL be one sub-module, byte_fifo (write/read ports, full/empty, count); no other sub-modules.

Verification
REQ-028 Defaults, cts_n=0, write 0x55 -> tx low at edge N+2, bits 1,0,1,0,1,0,1,0 each 36 cycles, stop high; total 360 cycles (396 with parity, parity bit 0).
REQ-029 Write 17 bytes 0x00..0x10 in consecutive cycles while cts_n=1 -> ready low after 16th, 17th ignored, tx stays high, busy=1.
REQ-030 Release cts_n=0 after REQ-029 -> 16 frames 0x00..0x0F with no gaps between stop and next start; busy falls after last stop bit.
REQ-031 Raise cts_n=1 during data bit 3 of 0xA3 -> frame completes intact; next queued byte held until cts_n=0.
REQ-032 Assert rst_n=0 during data bit 5 -> tx=1 same cycle, ready=1, busy=0; after release no residual frame.
REQ-033 With SERIAL_OUT_PARITY_EN, send 0x07 -> parity bit 1, stop bit at cycles 360..395 after start.
